// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI/host RAM arbiter slice.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_e;

  localparam int unsigned REQ_SPI  = 0;
  localparam int unsigned REQ_HOST = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin; priority only moves when both requesters contend.
module rr_arbiter2
  import spi_ram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output logic       prio_o
);

  logic prio_q;

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o         = '0;
      gnt_o[prio_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'(REQ_SPI);
    end else if (advance_i && (&req_i)) begin
      prio_q <= ~prio_q;
    end
  end

  assign prio_o = prio_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between decoded SPI commands and an on-chip host,
// holding one pending SPI access and arbitrating round-robin.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE+1:0] spi_rx_data,
  input  logic                 spi_rx_valid,
  output logic [DATA_SIZE-1:0] spi_tx_data,
  output logic                 spi_tx_valid,
  output logic                 spi_overrun,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [DATA_SIZE-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  state_e               state_q, state_d;
  logic                 rxv_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
  logic                 pend_valid_q, pend_we_q;
  logic [ADDR_SIZE-1:0] pend_addr_q;
  logic [DATA_SIZE-1:0] pend_data_q;
  logic                 win_host_q;
  logic                 mem_we_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [DATA_SIZE-1:0] mem_wdata_q;
  logic [DATA_SIZE-1:0] tx_data_q, host_rdata_q;
  logic                 tx_valid_q, overrun_q, host_rvalid_q;

  logic                 accept;
  logic [1:0]           cmd;
  logic [1:0]           arb_req, arb_gnt;
  logic                 arb_adv, arb_prio;

  assign accept  = spi_rx_valid & ~rxv_q;
  assign cmd     = spi_rx_data[DATA_SIZE+1:DATA_SIZE];
  assign arb_req = {host_req, pend_valid_q};

  rr_arbiter2 u_rr (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (arb_req),
    .advance_i(arb_adv),
    .gnt_o    (arb_gnt),
    .prio_o   (arb_prio)
  );

  always_comb begin
    state_d  = state_q;
    mem_en   = 1'b0;
    host_gnt = 1'b0;
    arb_adv  = 1'b0;
    case (state_q)
      ARB: begin
        if (|arb_req) begin
          arb_adv = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_en   = 1'b1;
        host_gnt = win_host_q;
        state_d  = mem_we_q ? ARB : RDATA;
      end
      RDATA:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      rxv_q         <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      pend_valid_q  <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      win_host_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rxv_q         <= spi_rx_valid;
      overrun_q     <= 1'b0;
      host_rvalid_q <= 1'b0;

      if (accept) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr_q <= spi_rx_data[ADDR_SIZE-1:0];
          CMD_RD_ADDR: rd_addr_q <= spi_rx_data[ADDR_SIZE-1:0];
          default: begin
            // A queued entry (even one being granted this cycle) blocks any new RAM command.
            if (pend_valid_q) begin
              overrun_q <= 1'b1;
            end else begin
              pend_valid_q <= 1'b1;
              pend_we_q    <= (cmd == CMD_WR_DATA);
              pend_addr_q  <= (cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
              pend_data_q  <= spi_rx_data[DATA_SIZE-1:0];
              if (cmd == CMD_RD_DATA) tx_valid_q <= 1'b0;
            end
          end
        endcase
      end

      if (arb_adv) begin
        win_host_q <= arb_gnt[REQ_HOST];
        if (arb_gnt[REQ_HOST]) begin
          mem_we_q    <= host_we;
          mem_addr_q  <= host_addr;
          mem_wdata_q <= host_wdata;
        end else begin
          mem_we_q    <= pend_we_q;
          mem_addr_q  <= pend_addr_q;
          mem_wdata_q <= pend_data_q;
        end
      end

      if (state_q == ACCESS && !win_host_q) pend_valid_q <= 1'b0;

      if (state_q == RDATA) begin
        if (win_host_q) begin
          host_rdata_q  <= mem_rdata;
          host_rvalid_q <= 1'b1;
        end else begin
          tx_data_q  <= mem_rdata;
          tx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign spi_tx_data  = tx_data_q;
  assign spi_tx_valid = tx_valid_q;
  assign spi_overrun  = overrun_q;
  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;

  a_contend_prio: assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB && (&arb_req)) |-> arb_gnt[arb_prio]);
  a_addr_range: assert property (@(posedge clk) disable iff (rst)
    mem_en |-> (32'(mem_addr) < MEM_DEPTH));

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed and randomized checks of spi_ram_arbiter against a RAM model and a
// transaction-level memory shadow.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid, spi_overrun;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       host_gnt, host_rvalid;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram    [256];
  logic [7:0] shadow [256];
  int wr_cnt = 0, en_cnt = 0, ovr_cnt = 0, w22_cnt = 0, rv_cnt = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_overrun(spi_overrun),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM plus activity counters.
  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
        if (mem_wdata == 8'h22) w22_cnt <= w22_cnt + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
    if (spi_overrun) ovr_cnt <= ovr_cnt + 1;
    if (host_rvalid) rv_cnt <= rv_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_send(input logic [1:0] c, input logic [7:0] p);
    spi_rx_data  = {c, p};
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    tick();
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    for (int i = 0; i < 10 && !host_gnt; i++) tick();
    check("hw_gnt", 8'(host_gnt), 8'd1);
    host_req = 1'b0;
    tick();
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    for (int i = 0; i < 10 && !host_gnt; i++) tick();
    check("hr_gnt", 8'(host_gnt), 8'd1);
    host_req = 1'b0;
    for (int i = 0; i < 10 && !host_rvalid; i++) tick();
    check("hr_rvalid", 8'(host_rvalid), 8'd1);
    d = host_rdata;
    tick();
  endtask

  initial begin
    logic [7:0] rd, m_wr, m_rd, a, d;
    int b0, b1;
    rst = 1'b1; spi_rx_data = '0; spi_rx_valid = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    tick(); tick(); tick();
    check("rst_mem_en", 8'(mem_en), 8'd0);
    check("rst_host_gnt", 8'(host_gnt), 8'd0);
    check("rst_rvalid", 8'(host_rvalid), 8'd0);
    check("rst_tx_valid", 8'(spi_tx_valid), 8'd0);
    check("rst_overrun", 8'(spi_overrun), 8'd0);
    check("rst_mem_addr", mem_addr, 8'h00);
    rst = 1'b0;
    tick();

    host_write(8'h10, 8'h77);
    host_write(8'h20, 8'h5A);

    // SPI write: address then data, access lands two cycles after the data accept
    spi_send(2'b00, 8'hA5);
    spi_send(2'b01, 8'h3C);
    check("spiw_en", 8'(mem_en), 8'd1);
    check("spiw_we", 8'(mem_we), 8'd1);
    check("spiw_addr", mem_addr, 8'hA5);
    check("spiw_wdata", mem_wdata, 8'h3C);
    check("spiw_nognt", 8'(host_gnt), 8'd0);
    tick();
    check("spiw_pulse", 8'(mem_en), 8'd0);
    tick();
    host_read(8'hA5, rd);
    check("spiw_ram", rd, 8'h3C);

    // SPI read latency and tx_valid persistence
    spi_send(2'b10, 8'h10);
    spi_send(2'b11, 8'h00);
    check("spir_en", 8'(mem_en), 8'd1);
    check("spir_we", 8'(mem_we), 8'd0);
    check("spir_addr", mem_addr, 8'h10);
    tick();
    check("spir_c3_txv", 8'(spi_tx_valid), 8'd0);
    tick();
    check("spir_c4_txv", 8'(spi_tx_valid), 8'd1);
    check("spir_data", spi_tx_data, 8'h77);
    spi_send(2'b00, 8'h55);
    check("spir_hold_txv", 8'(spi_tx_valid), 8'd1);
    check("spir_hold_data", spi_tx_data, 8'h77);

    // Host read latency
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    tick();
    check("hr_c1_gnt", 8'(host_gnt), 8'd1);
    check("hr_c1_addr", mem_addr, 8'h20);
    host_req = 1'b0;
    tick();
    check("hr_c2_rvalid", 8'(host_rvalid), 8'd0);
    tick();
    check("hr_c3_rvalid", 8'(host_rvalid), 8'd1);
    check("hr_c3_rdata", host_rdata, 8'h5A);
    tick();
    check("hr_c4_rvalid", 8'(host_rvalid), 8'd0);

    // Contention from reset: SPI first, then host; second round host first
    rst = 1'b1; tick(); rst = 1'b0; tick();
    spi_send(2'b00, 8'h40);
    spi_rx_data = {2'b01, 8'h99}; spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h41; host_wdata = 8'h66;
    tick();
    check("c1_spi_en", 8'(mem_en), 8'd1);
    check("c1_spi_addr", mem_addr, 8'h40);
    check("c1_spi_nognt", 8'(host_gnt), 8'd0);
    tick(); tick();
    check("c1_host_gnt", 8'(host_gnt), 8'd1);
    check("c1_host_addr", mem_addr, 8'h41);
    host_req = 1'b0;
    tick();
    spi_send(2'b00, 8'h50);
    spi_rx_data = {2'b01, 8'hAA}; spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h51; host_wdata = 8'hBB;
    tick();
    check("c2_host_gnt", 8'(host_gnt), 8'd1);
    check("c2_host_addr", mem_addr, 8'h51);
    host_req = 1'b0;
    tick(); tick();
    check("c2_spi_en", 8'(mem_en), 8'd1);
    check("c2_spi_addr", mem_addr, 8'h50);
    check("c2_spi_wdata", mem_wdata, 8'hAA);
    check("c2_spi_nognt", 8'(host_gnt), 8'd0);
    tick();

    // A level held high is accepted once
    spi_send(2'b00, 8'h30);
    b0 = wr_cnt; b1 = ovr_cnt;
    spi_rx_data = {2'b01, 8'h44}; spi_rx_valid = 1'b1;
    repeat (5) tick();
    spi_rx_valid = 1'b0;
    repeat (3) tick();
    check("level_writes", 8'(wr_cnt - b0), 8'd1);
    check("level_noovr", 8'(ovr_cnt - b1), 8'd0);

    // Overrun while host holds the RAM
    spi_send(2'b00, 8'h60);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    spi_rx_data = {2'b01, 8'h11}; spi_rx_valid = 1'b1;
    tick();
    check("ov_host_gnt", 8'(host_gnt), 8'd1);
    host_req = 1'b0; spi_rx_valid = 1'b0;
    tick();
    spi_rx_data = {2'b01, 8'h22}; spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
    check("ov_pulse", 8'(spi_overrun), 8'd1);
    check("ov_rvalid", 8'(host_rvalid), 8'd1);
    tick();
    check("ov_pulse_end", 8'(spi_overrun), 8'd0);
    check("ov_spi_addr", mem_addr, 8'h60);
    check("ov_spi_wdata", mem_wdata, 8'h11);
    repeat (4) tick();
    check("ov_no22", 8'(w22_cnt), 8'd0);
    host_read(8'h60, rd);
    check("ov_ram", rd, 8'h11);

    // Reset in RDATA with an SPI write still pending
    spi_send(2'b10, 8'h10);
    spi_send(2'b11, 8'h00);
    tick(); tick();
    check("rr_txv_pre", 8'(spi_tx_valid), 8'd1);
    spi_send(2'b00, 8'h70);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    spi_rx_data = {2'b01, 8'h33}; spi_rx_valid = 1'b1;
    tick();
    host_req = 1'b0; spi_rx_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rr_mem_en", 8'(mem_en), 8'd0);
    check("rr_mem_we", 8'(mem_we), 8'd0);
    check("rr_mem_addr", mem_addr, 8'h00);
    check("rr_mem_wdata", mem_wdata, 8'h00);
    check("rr_gnt", 8'(host_gnt), 8'd0);
    check("rr_rvalid", 8'(host_rvalid), 8'd0);
    check("rr_rdata", host_rdata, 8'h00);
    check("rr_txv", 8'(spi_tx_valid), 8'd0);
    check("rr_txd", spi_tx_data, 8'h00);
    check("rr_ovr", 8'(spi_overrun), 8'd0);
    rst = 1'b0;
    b0 = en_cnt; b1 = rv_cnt;
    repeat (6) tick();
    check("rr_no_access", 8'(en_cnt - b0), 8'd0);
    check("rr_no_rvalid", 8'(rv_cnt - b1), 8'd0);

    // Randomized serialized traffic against a memory shadow
    for (int i = 0; i < 16; i++) begin
      a = 8'hC0 | 8'(i);
      d = 8'($urandom);
      shadow[a] = d;
      host_write(a, d);
    end
    spi_send(2'b00, 8'hC0); m_wr = 8'hC0;
    spi_send(2'b10, 8'hC0); m_rd = 8'hC0;
    for (int i = 0; i < 60; i++) begin
      a = 8'hC0 | 8'($urandom_range(0, 15));
      d = 8'($urandom);
      case ($urandom_range(0, 5))
        0: begin spi_send(2'b00, a); m_wr = a; end
        1: begin spi_send(2'b10, a); m_rd = a; end
        2: begin spi_send(2'b01, d); shadow[m_wr] = d; tick(); end
        3: begin
          spi_send(2'b11, d);
          for (int k = 0; k < 8 && !spi_tx_valid; k++) tick();
          check("rnd_txv", 8'(spi_tx_valid), 8'd1);
          check("rnd_txd", spi_tx_data, shadow[m_rd]);
        end
        4: begin host_write(a, d); shadow[a] = d; end
        default: begin
          host_read(a, rd);
          check("rnd_hrd", rd, shadow[a]);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
